// File: rtl/conv_pass_sequencer.sv
// -----------------------------------------------------------------------------
// conv_pass_sequencer
//
// Runs a conv2d engine over a multi-pass job, one pass per coefficient bank.
// Each pass launches conv2d through its start pin, counts its write strobes
// until a full image has been produced, and remaps every result into a
// contiguous output window starting at the job base address. Successive passes
// land in back-to-back windows of ImagePixels words each.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset;
//                         i_rst must be the same net that resets conv2d
//   i_cfg_we/bank/coeff   coefficient bank write port
//   i_job_valid           job request; accepted together with o_job_ready
//   o_job_ready           high while idle
//   i_job_passes          number of passes (1..NumBanks, larger is clamped,
//                         0 completes immediately)
//   i_job_base            output base address of pass 0
//   o_conv_start          drives conv2d start
//   o_conv_f_coeff        drives conv2d f_coeff (stable for a whole pass)
//   i_conv_we, i_conv_d_out  conv2d WriteEnable and signed d_out
//   o_mem_we/addr/data    registered result memory write port
//   o_pass_idx            current pass number
//   o_busy, o_done, o_err busy flag, one-cycle done pulse, sticky error
//
// Build option:
//   CONV_SEQ_CLAMP_EN     when defined, results are saturated to the unsigned
//                         pixel range [0, 2^DataBitWidth-1] before being
//                         written; otherwise they pass through unchanged.
// -----------------------------------------------------------------------------
module conv_pass_sequencer #(
    parameter int AddressBitWidth = 17,
    parameter int DataBitWidth    = 12,
    parameter int FilterSize      = 5,
    parameter int FilterBitWidth  = 8,
    parameter int NumBanks        = 4,
    parameter int ImagePixels     = 2500,
    localparam int BankBits  = (NumBanks > 1) ? $clog2(NumBanks) : 1,
    localparam int PassBits  = BankBits + 1,
    localparam int CoeffBits = FilterSize * FilterSize * FilterBitWidth,
    localparam int OutBits   = DataBitWidth + FilterBitWidth
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cfg_we,
    input  logic [BankBits-1:0]        i_cfg_bank,
    input  logic [CoeffBits-1:0]       i_cfg_coeff,
    input  logic                       i_job_valid,
    output logic                       o_job_ready,
    input  logic [PassBits-1:0]        i_job_passes,
    input  logic [AddressBitWidth-1:0] i_job_base,
    output logic                       o_conv_start,
    output logic [CoeffBits-1:0]       o_conv_f_coeff,
    input  logic                       i_conv_we,
    input  logic [OutBits-1:0]         i_conv_d_out,
    output logic                       o_mem_we,
    output logic [AddressBitWidth-1:0] o_mem_addr,
    output logic [OutBits-1:0]         o_mem_data,
    output logic [BankBits-1:0]        o_pass_idx,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int PixBits = (ImagePixels > 1) ? $clog2(ImagePixels) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        GAP,
        LAUNCH,
        RUN,
        NEXT
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    logic [CoeffBits-1:0]       r_bank [NumBanks];
    logic [CoeffBits-1:0]       r_coeff;
    logic [PassBits-1:0]        r_passes;
    logic [BankBits-1:0]        r_pass_idx;
    logic [AddressBitWidth-1:0] r_base;
    logic [PixBits-1:0]         r_pix_cnt;
    logic                       r_conv_dirty;
    logic                       r_mem_we;
    logic [AddressBitWidth-1:0] r_mem_addr;
    logic [OutBits-1:0]         r_mem_data;
    logic                       r_done;
    logic                       r_err;

    logic                       w_last_pixel;
    logic                       w_last_pass;
    logic [PassBits-1:0]        w_passes_clamped;
    logic [OutBits-1:0]         w_mem_data;

    // The pass ends on the strobe that carries the last pixel of the image.
    assign w_last_pixel = (r_state == RUN) && i_conv_we &&
                          (r_pix_cnt == PixBits'(ImagePixels - 1));
    assign w_last_pass  = ({1'b0, r_pass_idx} == (r_passes - PassBits'(1)));

    // Requests for more passes than there are banks run every bank once.
    assign w_passes_clamped = (i_job_passes > PassBits'(NumBanks)) ?
                              PassBits'(NumBanks) : i_job_passes;

    // Result formatting. The clamp variant saturates signed filter output to
    // the unsigned pixel range; the default build forwards it untouched.
`ifdef CONV_SEQ_CLAMP_EN
    localparam logic [OutBits-1:0] MaxPixel = OutBits'((1 << DataBitWidth) - 1);

    always_comb begin
        w_mem_data = i_conv_d_out;
        if (i_conv_d_out[OutBits-1]) begin
            w_mem_data = '0;
        end else if (i_conv_d_out > MaxPixel) begin
            w_mem_data = MaxPixel;
        end
    end
`else
    always_comb begin
        w_mem_data = i_conv_d_out;
    end
`endif

    // State register for the pass sequencing FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs. conv2d needs a start pulse to
    // leave its complete state (RELEASE) and a separate one to begin a new
    // image (LAUNCH), with a low cycle in between so it sees two edges.
    always_comb begin
        w_next_state = r_state;
        o_conv_start = 1'b0;
        o_job_ready  = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                o_job_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_job_valid && (i_job_passes != '0)) begin
                    w_next_state = r_conv_dirty ? RELEASE : LAUNCH;
                end
            end
            RELEASE: begin
                o_conv_start = 1'b1;
                w_next_state = GAP;
            end
            GAP: begin
                w_next_state = LAUNCH;
            end
            LAUNCH: begin
                o_conv_start = 1'b1;
                w_next_state = RUN;
            end
            RUN: begin
                if (w_last_pixel) begin
                    w_next_state = NEXT;
                end
            end
            NEXT: begin
                w_next_state = w_last_pass ? IDLE : RELEASE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Coefficient bank storage, written by the host at any time. A write that
    // coincides with a launch of the same bank is not seen by that launch
    // because the launch samples the bank before this edge updates it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NumBanks; i++) begin
                r_bank[i] <= '0;
            end
        end else if (i_cfg_we && (int'(i_cfg_bank) < NumBanks)) begin
            r_bank[i_cfg_bank] <= i_cfg_coeff;
        end
    end

    // Job bookkeeping: pass count, pass index, window base, pixel counter,
    // the coefficient register feeding conv2d and the conv2d-dirty flag that
    // records whether conv2d is parked in its complete state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_passes     <= '0;
            r_pass_idx   <= '0;
            r_base       <= '0;
            r_pix_cnt    <= '0;
            r_coeff      <= '0;
            r_conv_dirty <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_job_valid) begin
                        if (i_job_passes == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_passes   <= w_passes_clamped;
                            r_base     <= i_job_base;
                            r_pass_idx <= '0;
                        end
                    end
                end
                RELEASE: begin
                    r_conv_dirty <= 1'b0;
                end
                LAUNCH: begin
                    r_coeff   <= r_bank[r_pass_idx];
                    r_pix_cnt <= '0;
                end
                RUN: begin
                    if (i_conv_we) begin
                        r_pix_cnt <= r_pix_cnt + PixBits'(1);
                    end
                    if (w_last_pixel) begin
                        r_conv_dirty <= 1'b1;
                    end
                end
                NEXT: begin
                    if (w_last_pass) begin
                        r_done <= 1'b1;
                    end else begin
                        r_pass_idx <= r_pass_idx + BankBits'(1);
                        r_base     <= r_base + AddressBitWidth'(ImagePixels);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered result write port. The conv2d write address is ignored; the
    // pixel's position comes from the strobe count, placed in the pass window.
    // Address and data hold their last value while no write is issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if ((r_state == RUN) && i_conv_we) begin
                r_mem_we   <= 1'b1;
                r_mem_addr <= r_base + AddressBitWidth'(r_pix_cnt);
                r_mem_data <= w_mem_data;
            end
        end
    end

    // A strobe from conv2d while no pass is running is dropped and flagged;
    // the flag stays set until reset so the host cannot miss it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_conv_we && (r_state != RUN)) begin
            r_err <= 1'b1;
        end
    end

    assign o_conv_f_coeff = r_coeff;
    assign o_mem_we       = r_mem_we;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_data     = r_mem_data;
    assign o_pass_idx     = r_pass_idx;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_pass_sequencer
//
// Directed bench for conv_pass_sequencer with default parameters. A short
// vector table covers the zero-pass job, the first launch after reset and
// result formatting; hand-written sequences cover full passes, back-to-back
// jobs, address wrap, reset in the middle of a pass, multi-pass windows and
// the sticky error flag.
// -----------------------------------------------------------------------------
module tb_conv_pass_sequencer;

    localparam int Aw = 17;
    localparam int Ow = 20;
    localparam int Cw = 200;
    localparam int Np = 2500;

    typedef struct {
        logic              jobValid;
        logic [2:0]        jobPasses;
        logic [Aw-1:0]     jobBase;
        logic              convWe;
        int                dOut;
        logic              expStart;
        logic              expReady;
        logic              expBusy;
        logic              expDone;
        logic              expMemWe;
        logic [Aw-1:0]     expAddr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfgWe;
    logic [1:0]    cfgBank;
    logic [Cw-1:0] cfgCoeff;
    logic          jobValid;
    logic          jobReady;
    logic [2:0]    jobPasses;
    logic [Aw-1:0] jobBase;
    logic          convStart;
    logic [Cw-1:0] convCoeff;
    logic          convWe;
    logic [Ow-1:0] convDOut;
    logic          memWe;
    logic [Aw-1:0] memAddr;
    logic [Ow-1:0] memData;
    logic [1:0]    passIdx;
    logic          busy;
    logic          done;
    logic          err;

    int checks     = 0;
    int failures   = 0;
    int startCount = 0;

    conv_pass_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cfg_we       (cfgWe),
        .i_cfg_bank     (cfgBank),
        .i_cfg_coeff    (cfgCoeff),
        .i_job_valid    (jobValid),
        .o_job_ready    (jobReady),
        .i_job_passes   (jobPasses),
        .i_job_base     (jobBase),
        .o_conv_start   (convStart),
        .o_conv_f_coeff (convCoeff),
        .i_conv_we      (convWe),
        .i_conv_d_out   (convDOut),
        .o_mem_we       (memWe),
        .o_mem_addr     (memAddr),
        .o_mem_data     (memData),
        .o_pass_idx     (passIdx),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Counts cycles with conv_start high, sampled mid-cycle.
    always @(negedge clk) begin
        if (convStart) startCount++;
    end

    // Expected memory data for a given conv2d result.
    function automatic logic [Ow-1:0] expData(input int v);
`ifdef CONV_SEQ_CLAMP_EN
        if (v < 0) return '0;
        if (v > 4095) return Ow'(4095);
        return Ow'(v);
`else
        return Ow'(v);
`endif
    endfunction

    function automatic vec_t mkVec(input logic valid, input logic [2:0] passes,
                                   input logic [Aw-1:0] base, input logic we, input int d,
                                   input logic s, input logic r, input logic b,
                                   input logic dn, input logic mw, input logic [Aw-1:0] addr);
        vec_t v;
        v.jobValid = valid; v.jobPasses = passes; v.jobBase = base;
        v.convWe = we; v.dOut = d;
        v.expStart = s; v.expReady = r; v.expBusy = b; v.expDone = dn;
        v.expMemWe = mw; v.expAddr = addr;
        return v;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        jobValid  = v.jobValid;
        jobPasses = v.jobPasses;
        jobBase   = v.jobBase;
        convWe    = v.convWe;
        convDOut  = Ow'(v.dOut);
    endtask

    task automatic idleInputs();
        cfgWe     = 1'b0;
        cfgBank   = '0;
        cfgCoeff  = '0;
        jobValid  = 1'b0;
        jobPasses = '0;
        jobBase   = '0;
        convWe    = 1'b0;
        convDOut  = '0;
    endtask

    task automatic loadBank(input logic [1:0] b, input logic [Cw-1:0] c);
        cfgWe    = 1'b1;
        cfgBank  = b;
        cfgCoeff = c;
        stepCycle();
        cfgWe    = 1'b0;
    endtask

    // Feeds pixels first..last of a pass (state must be RUN) and checks each
    // resulting memory write, then the pass index and coefficients.
    task automatic runPass(input logic [Aw-1:0] base, input int first, input int last,
                           input logic [1:0] pidx, input logic [Cw-1:0] coeff);
        logic [Aw-1:0] expA;
        for (int p = first; p <= last; p++) begin
            convWe   = 1'b1;
            convDOut = Ow'(p);
            stepCycle();
            expA = base + Aw'(p);
            checkOutput($sformatf("pass%0d px%0d mem_we", pidx, p), memWe, 1'b1);
            checkOutput($sformatf("pass%0d px%0d addr", pidx, p), memAddr, expA);
            checkOutput($sformatf("pass%0d px%0d data", pidx, p), memData, expData(p));
        end
        convWe = 1'b0;
        checkOutput($sformatf("pass%0d pass_idx", pidx), passIdx, pidx);
        checkOutput($sformatf("pass%0d coeff", pidx), convCoeff, coeff);
    endtask

    initial begin
        vec_t          vecs[9];
        logic [Cw-1:0] c0, c1, c1b, c2;
        int            startBase;

        c0 = '0;
        c0[12*8 +: 8] = 8'd1;
        c1  = {25{8'h03}};
        c1b = {25{8'h7F}};
        for (int k = 0; k < 25; k++) c2[k*8 +: 8] = 8'(k + 1);

        vecs[0] = mkVec(1, 0, 17'h0,    0, 0,    0, 1, 0, 1, 0, 17'h0);
        vecs[1] = mkVec(0, 0, 17'h0,    0, 0,    0, 1, 0, 0, 0, 17'h0);
        vecs[2] = mkVec(1, 1, 17'h1000, 0, 0,    1, 0, 1, 0, 0, 17'h0);
        vecs[3] = mkVec(0, 0, 17'h0,    0, 0,    0, 0, 1, 0, 0, 17'h0);
        vecs[4] = mkVec(0, 0, 17'h0,    1, 7,    0, 0, 1, 0, 1, 17'h1000);
        vecs[5] = mkVec(0, 0, 17'h0,    0, 0,    0, 0, 1, 0, 0, 17'h0);
        vecs[6] = mkVec(0, 0, 17'h0,    1, -5,   0, 0, 1, 0, 1, 17'h1001);
        vecs[7] = mkVec(0, 0, 17'h0,    1, 5000, 0, 0, 1, 0, 1, 17'h1002);
        vecs[8] = mkVec(0, 0, 17'h0,    1, 300,  0, 0, 1, 0, 1, 17'h1003);

        // Reset values.
        idleInputs();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst conv_start", convStart, 1'b0);
        checkOutput("rst coeff", convCoeff, '0);
        checkOutput("rst mem_we", memWe, 1'b0);
        checkOutput("rst mem_addr", memAddr, '0);
        checkOutput("rst mem_data", memData, '0);
        checkOutput("rst pass_idx", passIdx, '0);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst done", done, 1'b0);
        checkOutput("rst err", err, 1'b0);
        checkOutput("rst job_ready", jobReady, 1'b1);
        rst = 1'b0;
        stepCycle();
        loadBank(2'd0, c0);

        // Zero-pass job, first launch after reset, result formatting.
        startBase = startCount;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d start", i), convStart, vecs[i].expStart);
            checkOutput($sformatf("vec%0d ready", i), jobReady, vecs[i].expReady);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d done", i), done, vecs[i].expDone);
            checkOutput($sformatf("vec%0d mem_we", i), memWe, vecs[i].expMemWe);
            if (vecs[i].expMemWe) begin
                checkOutput($sformatf("vec%0d addr", i), memAddr, vecs[i].expAddr);
                checkOutput($sformatf("vec%0d data", i), memData, expData(vecs[i].dOut));
            end
        end
        applyStimulus(mkVec(0, 0, 17'h0, 0, 0, 0, 0, 0, 0, 0, 17'h0));

        // Rest of the single pass; last address is 0x19C3.
        runPass(17'h1000, 4, Np - 1, 2'd0, c0);
        checkOutput("single next done", done, 1'b0);
        checkOutput("single next busy", busy, 1'b1);
        stepCycle();
        checkOutput("single done", done, 1'b1);
        checkOutput("single done busy", busy, 1'b0);
        checkOutput("single done ready", jobReady, 1'b1);
        checkOutput("single done mem_we", memWe, 1'b0);
        checkOutput("single start pulses", startCount - startBase, 1);

        // Back-to-back job at the top of memory: start goes 1,0,1 and the
        // second write wraps to address 0.
        jobValid  = 1'b1;
        jobPasses = 3'd1;
        jobBase   = 17'h1FFFF;
        stepCycle();
        jobValid = 1'b0;
        checkOutput("b2b release start", convStart, 1'b1);
        stepCycle();
        checkOutput("b2b gap start", convStart, 1'b0);
        checkOutput("b2b gap busy", busy, 1'b1);
        stepCycle();
        checkOutput("b2b launch start", convStart, 1'b1);
        stepCycle();
        checkOutput("b2b run start", convStart, 1'b0);
        checkOutput("b2b no early mem_we", memWe, 1'b0);
        runPass(17'h1FFFF, 0, 999, 2'd0, c0);
        checkOutput("wrap addr px999", memAddr, 17'(999 - 1));

        // Reset in the middle of the pass clears everything at once.
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst mem_we", memWe, 1'b0);
        checkOutput("midrst mem_addr", memAddr, '0);
        checkOutput("midrst mem_data", memData, '0);
        checkOutput("midrst busy", busy, 1'b0);
        checkOutput("midrst ready", jobReady, 1'b1);
        checkOutput("midrst start", convStart, 1'b0);
        checkOutput("midrst coeff", convCoeff, '0);
        checkOutput("midrst pass_idx", passIdx, '0);
        checkOutput("midrst err", err, 1'b0);
        #1;
        rst = 1'b0;
        stepCycle();

        // Next job launches directly (no release pulse).
        jobValid  = 1'b1;
        jobPasses = 3'd1;
        jobBase   = 17'h200;
        stepCycle();
        jobValid = 1'b0;
        checkOutput("relaunch start", convStart, 1'b1);
        stepCycle();
        checkOutput("relaunch run start", convStart, 1'b0);
        checkOutput("relaunch busy", busy, 1'b1);
        stepCycle();
        checkOutput("relaunch still run", convStart, 1'b0);
        convWe   = 1'b1;
        convDOut = Ow'(42);
        stepCycle();
        convWe = 1'b0;
        checkOutput("relaunch mem_we", memWe, 1'b1);
        checkOutput("relaunch addr", memAddr, 17'h200);

        // Fresh reset, then a three-pass job with distinct banks.
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        loadBank(2'd0, c0);
        loadBank(2'd1, c1);
        loadBank(2'd2, c2);
        startBase = startCount;
        jobValid  = 1'b1;
        jobPasses = 3'd3;
        jobBase   = 17'h0;
        stepCycle();
        jobValid = 1'b0;
        checkOutput("3p launch0 start", convStart, 1'b1);
        checkOutput("3p launch0 pass_idx", passIdx, 2'd0);
        stepCycle();
        runPass(17'd0, 0, Np - 1, 2'd0, c0);
        stepCycle();
        checkOutput("3p release1 start", convStart, 1'b1);
        checkOutput("3p release1 pass_idx", passIdx, 2'd1);
        checkOutput("3p release1 mem_we", memWe, 1'b0);
        stepCycle();
        checkOutput("3p gap1 start", convStart, 1'b0);
        stepCycle();
        checkOutput("3p launch1 start", convStart, 1'b1);
        // Overwrite bank1 during its own launch: this pass keeps the old set.
        cfgWe    = 1'b1;
        cfgBank  = 2'd1;
        cfgCoeff = c1b;
        stepCycle();
        cfgWe = 1'b0;
        checkOutput("3p run1 start", convStart, 1'b0);
        runPass(17'd2500, 0, Np - 1, 2'd1, c1);
        stepCycle();
        checkOutput("3p release2 start", convStart, 1'b1);
        checkOutput("3p release2 pass_idx", passIdx, 2'd2);
        stepCycle();
        checkOutput("3p gap2 start", convStart, 1'b0);
        stepCycle();
        checkOutput("3p launch2 start", convStart, 1'b1);
        stepCycle();
        runPass(17'd5000, 0, Np - 1, 2'd2, c2);
        checkOutput("3p next done", done, 1'b0);
        stepCycle();
        checkOutput("3p done", done, 1'b1);
        checkOutput("3p done busy", busy, 1'b0);
        checkOutput("3p start pulses", startCount - startBase, 5);
        checkOutput("3p err clear", err, 1'b0);

        // Strobe while idle is dropped and flags a sticky error.
        convWe   = 1'b1;
        convDOut = Ow'(9);
        stepCycle();
        convWe = 1'b0;
        checkOutput("idle we err", err, 1'b1);
        checkOutput("idle we mem_we", memWe, 1'b0);
        stepCycle();
        checkOutput("err sticky", err, 1'b1);
        checkOutput("idle we no done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
